// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait freeze, load-use bubble,
// branch flush of IF/ID, memory-timeout error and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memRead_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memAccess_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_set;
    logic              load_use;
    logic              hazard_en;

    assign load_use = idex_memRead_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                err_o <= 1'b1;
            if (!pc_write_o && stall_cnt_o != CNT_MAX)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_nxt       = wait_cnt;
        err_set        = 1'b0;
        hazard_en      = 1'b0;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_flush_o   = 1'b0;
        exmem_write_o  = 1'b1;
        memwb_bubble_o = 1'b0;
        dmem_req_o     = 1'b0;

        if (!rst_n_i) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_flush_o   = 1'b1;
            memwb_bubble_o = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    dmem_req_o = exmem_memAccess_i;
                    if (exmem_memAccess_i && !dmem_ready_i) begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else begin
                        hazard_en = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req_o = 1'b1;
                    if (dmem_ready_i) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                        hazard_en = 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERR;
                        err_set   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
                default: state_nxt = ERR;
            endcase

            // Anything not cleared to run the hazard logic is a full freeze.
            if (!hazard_en) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_write_o  = 1'b0;
                memwb_bubble_o = 1'b1;
            end else if (load_use) begin
                // A branch seen together with a load-use is dropped; ID re-resolves it.
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // Output vector order: pc, ifid_w, ifid_fl, idex_w, idex_fl, exmem_w, bubble, req, err
    localparam logic [8:0] NORM   = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] NORM_R = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] FREEZE = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] LU     = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] BR     = 9'b1_1_1_1_0_1_0_0_0;
    localparam logic [8:0] RST    = 9'b0_0_1_0_1_0_1_0_0;
    localparam logic [8:0] ERRV   = 9'b0_0_0_0_0_0_1_0_1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       ifid_rs, ifid_rt, idex_rt;
    logic             idex_memRead, branch_taken, exmem_memAccess, dmem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic             exmem_write, memwb_bubble, dmem_req, err;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       obs;

    int checks = 0;
    int errors = 0;

    assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                  exmem_write, memwb_bubble, dmem_req, err};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
        .idex_memRead_i(idex_memRead), .idex_rt_i(idex_rt),
        .branch_taken_i(branch_taken), .exmem_memAccess_i(exmem_memAccess),
        .dmem_ready_i(dmem_ready),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_write_o(idex_write), .idex_flush_o(idex_flush),
        .exmem_write_o(exmem_write), .memwb_bubble_o(memwb_bubble),
        .dmem_req_o(dmem_req), .err_o(err), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
        idex_memRead = 1'b0; branch_taken = 1'b0;
        exmem_memAccess = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        #2;
        checks++;
        if (obs !== RST) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, RST);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mem_stall();
        exmem_memAccess = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (obs !== FREEZE) begin
                errors++;
                $display("FAIL mem_freeze[%0d]: got %b expected %b", i, obs, FREEZE);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (obs !== NORM_R) begin
            errors++;
            $display("FAIL mem_release: got %b expected %b", obs, NORM_R);
        end
        tick();
        idle();
        #2;
        checks++;
        if (obs !== NORM || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL mem_after: got %b/%0d expected %b/3", obs, stall_cnt, NORM);
        end
        tick();
    endtask

    task automatic test_load_use();
        idex_memRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #2;
        checks++;
        if (obs !== LU) begin
            errors++;
            $display("FAIL lu_rs: got %b expected %b", obs, LU);
        end
        tick();
        idle();
        #2;
        checks++;
        if (obs !== NORM || stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL lu_after: got %b/%0d expected %b/4", obs, stall_cnt, NORM);
        end
        tick();
        idex_memRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #2;
        checks++;
        if (obs !== NORM) begin
            errors++;
            $display("FAIL lu_r0: got %b expected %b", obs, NORM);
        end
        tick();
        idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9;
        #2;
        checks++;
        if (obs !== LU) begin
            errors++;
            $display("FAIL lu_rt: got %b expected %b", obs, LU);
        end
        tick();
        idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd4;
        #2;
        checks++;
        if (obs !== NORM || stall_cnt !== 4'd5) begin
            errors++;
            $display("FAIL lu_nomatch: got %b/%0d expected %b/5", obs, stall_cnt, NORM);
        end
        tick();
        idle();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        #2;
        checks++;
        if (obs !== BR) begin
            errors++;
            $display("FAIL br_alone: got %b expected %b", obs, BR);
        end
        tick();
        branch_taken = 1'b0;
        #2;
        checks++;
        if (obs !== NORM) begin
            errors++;
            $display("FAIL br_after: got %b expected %b", obs, NORM);
        end
        tick();
        branch_taken = 1'b1; idex_memRead = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
        #2;
        checks++;
        if (obs !== LU) begin
            errors++;
            $display("FAIL br_lu: got %b expected %b", obs, LU);
        end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        exmem_memAccess = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (obs !== FREEZE) begin
                errors++;
                $display("FAIL to_wait[%0d]: got %b expected %b", i, obs, FREEZE);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (obs !== ERRV || stall_cnt !== 4'd10) begin
            errors++;
            $display("FAIL to_err: got %b/%0d expected %b/10", obs, stall_cnt, ERRV);
        end
        tick();
        idle();
        #2;
        checks++;
        if (obs !== ERRV) begin
            errors++;
            $display("FAIL to_sticky: got %b expected %b", obs, ERRV);
        end
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs[8:1] !== RST[8:1]) begin
            errors++;
            $display("FAIL to_rst: got %b expected %b", obs[8:1], RST[8:1]);
        end
        tick();
        rst_n = 1'b1;
        #2;
        checks++;
        if (obs !== NORM || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL to_clear: got %b/%0d expected %b/0", obs, stall_cnt, NORM);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        exmem_memAccess = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs !== RST) begin
            errors++;
            $display("FAIL mid_rst: got %b expected %b", obs, RST);
        end
        tick();
        rst_n = 1'b1;
        exmem_memAccess = 1'b0;
        #2;
        checks++;
        if (obs !== NORM || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_run: got %b/%0d expected %b/0", obs, stall_cnt, NORM);
        end
        tick();
        exmem_memAccess = 1'b1;
        #2;
        checks++;
        if (obs !== FREEZE) begin
            errors++;
            $display("FAIL mid_retry: got %b expected %b", obs, FREEZE);
        end
        tick();
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (obs !== NORM_R) begin
            errors++;
            $display("FAIL mid_done: got %b expected %b", obs, NORM_R);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idex_memRead = 1'b1; idex_rt = 5'd2; ifid_rt = 5'd2;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (stall_cnt !== ((i > 15) ? 4'd15 : 4'(i))) begin
                errors++;
                $display("FAIL sat[%0d]: got %0d expected %0d", i, stall_cnt,
                         (i > 15) ? 15 : i);
            end
        end
        idle();
        tick();
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_mem_stall();
        test_load_use();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
